// File: rtl/aesl_deadlock_block_reporter.sv
// aesl_deadlock_block_reporter: counts consecutive kernel-blocked cycles and reports a one-shot deadlock snapshot
module aesl_deadlock_block_reporter #(
  parameter int AXIS_W = 2,
  parameter int INST_W = 2,
  parameter int THRESH = 16
) (
  input  logic              kernel_monitor_clock,
  input  logic              kernel_monitor_reset,
  input  logic              enable,
  input  logic              kernel_block,
  input  logic [AXIS_W-1:0] axis_block_sigs,
  input  logic [INST_W-1:0] inst_idle_sigs,
  output logic              report_valid,
  input  logic              report_ready,
  output logic [AXIS_W-1:0] report_axis,
  output logic [INST_W-1:0] report_idle,
  output logic [31:0]       report_time,
  output logic [15:0]       block_cnt,
  output logic              deadlock
);
  typedef enum logic [1:0] {IDLE, COUNT, REPORT, HALT} state_t;
  localparam logic [15:0] TH    = 16'(THRESH);
  localparam logic [15:0] TH_M1 = 16'(THRESH - 1);
  state_t            r_state, w_state_nxt;
  logic [15:0]       r_cnt, w_cnt_nxt;
  logic [31:0]       r_cycle;
  logic [AXIS_W-1:0] r_axis;
  logic [INST_W-1:0] r_idle;
  logic [31:0]       r_time;
  logic              r_dead;
  logic              w_cap;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cap       = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = (enable && kernel_block) ? COUNT : IDLE;
        w_cnt_nxt   = (enable && kernel_block) ? 16'd1 : 16'd0;
      end
      COUNT: begin
        if (!enable || !kernel_block) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 16'd0;
        end else if (r_cnt == TH_M1) begin
          w_state_nxt = REPORT;
          w_cnt_nxt   = TH;
          w_cap       = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      REPORT: begin
        w_state_nxt = report_ready ? HALT : REPORT;
        w_cnt_nxt   = TH;
      end
      default: w_cnt_nxt = TH;
    endcase
  end
  always_ff @(posedge kernel_monitor_clock) begin
    if (kernel_monitor_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cycle <= '0;
      r_axis  <= '0;
      r_idle  <= '0;
      r_time  <= '0;
      r_dead  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cycle <= r_cycle + 32'd1;
      if (w_cap) begin
        r_axis <= axis_block_sigs;
        r_idle <= inst_idle_sigs;
        r_time <= r_cycle;
        r_dead <= 1'b1;
      end
    end
  end
  assign report_valid = (r_state == REPORT);
  assign report_axis  = r_axis;
  assign report_idle  = r_idle;
  assign report_time  = r_time;
  assign block_cnt    = r_cnt;
  assign deadlock     = r_dead;
endmodule

// File: tb/tb_aesl_deadlock_block_reporter.sv
// tb_aesl_deadlock_block_reporter: directed checks of detection, handshake, reset and timestamp wrap with THRESH=4
module tb_aesl_deadlock_block_reporter;
  logic        clk = 1'b0;
  logic        rst, en, kb, ready;
  logic [1:0]  axis, idle;
  logic        valid, dead;
  logic [1:0]  r_axis, r_idle;
  logic [31:0] r_time;
  logic [15:0] cnt;
  int          n_tests = 0;
  int          n_fail  = 0;
  aesl_deadlock_block_reporter #(.AXIS_W(2), .INST_W(2), .THRESH(4)) dut (
    .kernel_monitor_clock(clk),
    .kernel_monitor_reset(rst),
    .enable(en),
    .kernel_block(kb),
    .axis_block_sigs(axis),
    .inst_idle_sigs(idle),
    .report_valid(valid),
    .report_ready(ready),
    .report_axis(r_axis),
    .report_idle(r_idle),
    .report_time(r_time),
    .block_cnt(cnt),
    .deadlock(dead)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1; en = 1'b0; kb = 1'b0; ready = 1'b0; axis = 2'b00; idle = 2'b00;
    tick(2);
    rst = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_dead"},  {31'd0, dead},  32'd0);
    chk({tag, "_cnt"},   {16'd0, cnt},   32'd0);
    chk({tag, "_axis"},  {30'd0, r_axis}, 32'd0);
    chk({tag, "_idle"},  {30'd0, r_idle}, 32'd0);
    chk({tag, "_time"},  r_time,          32'd0);
  endtask
  initial begin
    do_reset();
    chk_zero("rst0");
    // Basic detection: blocked on edges 10..13, snapshot taken at edge 13
    en = 1'b1;
    tick(10);
    kb = 1'b1;
    tick(3);
    chk("det_cnt3", {16'd0, cnt}, 32'd3);
    chk("det_pre_valid", {31'd0, valid}, 32'd0);
    axis = 2'b10; idle = 2'b10;
    tick();
    chk("det_valid", {31'd0, valid}, 32'd1);
    chk("det_axis", {30'd0, r_axis}, 32'd2);
    chk("det_idle", {30'd0, r_idle}, 32'd2);
    chk("det_time", r_time, 32'd13);
    chk("det_dead", {31'd0, dead}, 32'd1);
    chk("det_cnt4", {16'd0, cnt}, 32'd4);
    // Backpressure: report must hold while inputs churn
    for (int i = 0; i < 5; i++) begin
      ready = 1'b0; axis = 2'(i); idle = ~2'(i); kb = i[0]; en = ~i[1];
      tick();
      chk("hold_valid", {31'd0, valid}, 32'd1);
      chk("hold_axis", {30'd0, r_axis}, 32'd2);
      chk("hold_time", r_time, 32'd13);
      chk("hold_cnt", {16'd0, cnt}, 32'd4);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("acc_valid", {31'd0, valid}, 32'd0);
    chk("acc_dead", {31'd0, dead}, 32'd1);
    chk("acc_time", r_time, 32'd13);
    chk("acc_idle", {30'd0, r_idle}, 32'd2);
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      kb = (i != 3); ready = i[0];
      tick();
      chk("halt_valid", {31'd0, valid}, 32'd0);
      chk("halt_cnt", {16'd0, cnt}, 32'd4);
    end
    // Interrupted run: 1,2,3,0,1,2,3,4 on edges 10..17
    do_reset();
    en = 1'b1;
    tick(10);
    for (int i = 10; i <= 17; i++) begin
      kb = (i != 13);
      tick();
      chk("run_cnt", {16'd0, cnt}, (i < 13) ? 32'(i - 9) : (i == 13) ? 32'd0 : 32'(i - 13));
    end
    chk("run_valid", {31'd0, valid}, 32'd1);
    chk("run_time", r_time, 32'd17);
    // Reset in REPORT, with reset outranking active inputs
    rst = 1'b1;
    tick();
    chk_zero("rst_rep");
    rst = 1'b0;
    tick(3);
    chk("rst_rep_cnt3", {16'd0, cnt}, 32'd3);
    tick();
    chk("rst_restart_valid", {31'd0, valid}, 32'd1);
    chk("rst_restart_time", r_time, 32'd3);
    // Reset while counting at 3
    do_reset();
    en = 1'b1; kb = 1'b1;
    tick(3);
    chk("mid_cnt3", {16'd0, cnt}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("rst_mid");
    // Enable dropped at edge 12; ready in IDLE/COUNT ignored
    do_reset();
    en = 1'b1; ready = 1'b1;
    tick(10);
    kb = 1'b1;
    tick(2);
    chk("en_cnt2", {16'd0, cnt}, 32'd2);
    en = 1'b0;
    tick();
    chk("en_drop_cnt", {16'd0, cnt}, 32'd0);
    en = 1'b1;
    for (int i = 13; i <= 16; i++) begin
      tick();
      chk("en_re_cnt", {16'd0, cnt}, 32'(i - 12));
    end
    chk("en_valid", {31'd0, valid}, 32'd1);
    chk("en_time", r_time, 32'd16);
    chk("en_ready_noeff_dead", {31'd0, dead}, 32'd1);
    // Timestamp wrap: counter preset to 0xFFFFFFFE, detection lands after wrap
    do_reset();
    force dut.r_cycle = 32'hFFFF_FFFE;
    release dut.r_cycle;
    en = 1'b1; kb = 1'b1; axis = 2'b01; idle = 2'b11;
    tick(4);
    chk("wrap_valid", {31'd0, valid}, 32'd1);
    chk("wrap_time", r_time, 32'd1);
    chk("wrap_axis", {30'd0, r_axis}, 32'd1);
    chk("wrap_idle", {30'd0, r_idle}, 32'd3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
